// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational D-bit add/subtract slice built from ripple-chained 1-bit cells.
// cin/cout carry the carry for add and the borrow for subtract.
module digit_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned D = 2
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  input  logic         op,
  output logic [D-1:0] s,
  output logic         cout
);

  logic [D:0] c;
  logic       inv_a;

  assign c[0]  = cin;
  assign inv_a = (op == OP_SUB);
  assign cout  = c[D];

  // Borrow-out equals the carry-out majority with a inverted.
  for (genvar i = 0; i < int'(D); i++) begin : g_cell
    logic am;
    assign am       = a[i] ^ inv_a;
    assign s[i]     = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (am & b[i]) | (am & c[i]) | (b[i] & c[i]);
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle unsigned add/subtract: D bits per cycle, LSB digit first,
// subtract results returned as magnitude plus borrow flag.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] y,
  output logic         flag,
  output logic         zero
);

  localparam int unsigned NDIG = N / D;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((N % D) != 0 || N < 2 || D < 1) begin : g_param_err
    $error("serial_addsub: N must be >= 2 and a multiple of D");
  end

  state_t         state, state_nx;
  logic [N-1:0]   a_q, b_q, res_q;
  logic           op_q, cy_q;
  logic [CW-1:0]  cnt;

  logic           accept_c, last_c;
  logic [D-1:0]   s_c;
  logic           cout_c;
  logic [N-1:0]   y_c;

  assign accept_c = start && ready;
  assign last_c   = (cnt == CW'(NDIG - 1));

  digit_addsub #(.D(D)) u_digit (
    .a    (a_q[D-1:0]),
    .b    (b_q[D-1:0]),
    .cin  (cy_q),
    .op   (op_q),
    .s    (s_c),
    .cout (cout_c)
  );

  // Final borrow on subtract means the partial result is a - b mod 2^N; negate it.
  assign y_c = (op_q == OP_SUB && cy_q) ? (~res_q + N'(1)) : res_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c) state_nx = RUN;
      RUN:     if (last_c)   state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = accept_c ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      ready <= (state_nx == IDLE) || (state_nx == DONE);
      done  <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
      res_q <= '0;
      cy_q  <= 1'b0;
      cnt   <= '0;
      y     <= '0;
      flag  <= 1'b0;
      zero  <= 1'b1;
    end else begin
      if (accept_c) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        res_q <= '0;
        cy_q  <= 1'b0;
        cnt   <= '0;
      end else if (state == RUN) begin
        // Consume the low digit; the result fills from the top down.
        a_q   <= a_q >> D;
        b_q   <= b_q >> D;
        res_q <= N'({s_c, res_q} >> D);
        cy_q  <= cout_c;
        cnt   <= cnt + CW'(1);
      end
      if (state == FIX) begin
        y    <= y_c;
        flag <= cy_q;
        zero <= (y_c == '0);
      end
    end
  end

endmodule
